// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: per-axis timing record, standard modes and their totals.
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int frontPorch;
        int synch;
        int backPorch;
    } axis_timing_t;

    // Full period of one axis, in pixels (horizontal) or lines (vertical).
    function automatic int axisTotal(input int active, input int frontPorch,
                                     input int synch, input int backPorch);
        return active + frontPorch + synch + backPorch;
    endfunction

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock.
    localparam axis_timing_t VGA640_H = '{640, 16, 96, 48};
    localparam axis_timing_t VGA640_V = '{480, 10, 2, 33};
    localparam int VGA640_H_TOTAL = axisTotal(640, 16, 96, 48);
    localparam int VGA640_V_TOTAL = axisTotal(480, 10, 2, 33);

    // 800x600 @ 60 Hz, 40 MHz pixel clock.
    localparam axis_timing_t VGA800_H = '{800, 40, 128, 88};
    localparam axis_timing_t VGA800_V = '{600, 1, 4, 23};
    localparam int VGA800_H_TOTAL = axisTotal(800, 40, 128, 88);
    localparam int VGA800_V_TOTAL = axisTotal(600, 1, 4, 23);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus between the generator (master) and a pixel pipeline consuming it (slave).
interface vga_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             enable;
    logic             h_synch;
    logic             v_synch;
    logic             blank;
    logic [CNT_W-1:0] pixel_count;
    logic [CNT_W-1:0] line_count;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  enable,
        output h_synch, v_synch, blank, pixel_count, line_count, line_start, frame_start
    );

    modport slave (
        output enable,
        input  h_synch, v_synch, blank, pixel_count, line_count, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter plus registered sync decode. The next-count view is
// decoded so that the registered sync always describes the count shown in the same cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE      = 640,
    parameter int FRONT_PORCH = 16,
    parameter int SYNCH       = 96,
    parameter int BACK_PORCH  = 48,
    parameter bit SYNCH_POL   = 1'b0,
    parameter int CNT_W       = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sync_o,
    output logic             nextActive_o,
    output logic             wrap_o
);

    localparam int TOTAL = axisTotal(ACTIVE, FRONT_PORCH, SYNCH, BACK_PORCH);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FRONT_PORCH);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FRONT_PORCH + SYNCH - 1);

    // A timing that cannot be counted in CNT_W bits, or has an empty porch/sync, is refused.
    generate
        if ((longint'(TOTAL) > (longint'(1) << CNT_W)) ||
            (FRONT_PORCH < 1) || (SYNCH < 1) || (BACK_PORCH < 1)) begin : gBadTiming
            $error("vga_axis_counter: illegal timing for CNT_W");
        end
    endgenerate

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q, sync_d;

    // Next count, wrap detection, and decode of the position about to be shown.
    always_comb begin
        wrap_o  = advance_i && (count_q == LAST);
        count_d = count_q;
        if (advance_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
        sync_d       = ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? SYNCH_POL : !SYNCH_POL;
        nextActive_o = (count_d < ACTIVE_END);
    end

    // Reset parks the axis on its last position so the first step lands on zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= LAST;
            sync_q  <= !SYNCH_POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters plus aligned
// blanking and line/frame start pulses, all registered together.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE      = VGA640_H.active,
    parameter int H_FRONT_PORCH = VGA640_H.frontPorch,
    parameter int H_SYNCH       = VGA640_H.synch,
    parameter int H_BACK_PORCH  = VGA640_H.backPorch,
    parameter int V_ACTIVE      = VGA640_V.active,
    parameter int V_FRONT_PORCH = VGA640_V.frontPorch,
    parameter int V_SYNCH       = VGA640_V.synch,
    parameter int V_BACK_PORCH  = VGA640_V.backPorch,
    parameter bit H_SYNCH_POL   = 1'b0,
    parameter bit V_SYNCH_POL   = 1'b0,
    parameter int CNT_W         = 12
) (
    input logic              pixel_clock,
    input logic              reset,
    vga_timing_gen_if.master bus
);

    logic [CNT_W-1:0] hCount, vCount;
    logic             hSync, vSync;
    logic             hNextActive, vNextActive;
    logic             hWrap, vWrap;
    logic             blank_q, blank_d;
    logic             lineStart_q, lineStart_d;
    logic             frameStart_q, frameStart_d;

    vga_axis_counter #(
        .ACTIVE      (H_ACTIVE),
        .FRONT_PORCH (H_FRONT_PORCH),
        .SYNCH       (H_SYNCH),
        .BACK_PORCH  (H_BACK_PORCH),
        .SYNCH_POL   (H_SYNCH_POL),
        .CNT_W       (CNT_W)
    ) uHorizontal (
        .clock        (pixel_clock),
        .reset        (reset),
        .advance_i    (bus.enable),
        .count_o      (hCount),
        .sync_o       (hSync),
        .nextActive_o (hNextActive),
        .wrap_o       (hWrap)
    );

    vga_axis_counter #(
        .ACTIVE      (V_ACTIVE),
        .FRONT_PORCH (V_FRONT_PORCH),
        .SYNCH       (V_SYNCH),
        .BACK_PORCH  (V_BACK_PORCH),
        .SYNCH_POL   (V_SYNCH_POL),
        .CNT_W       (CNT_W)
    ) uVertical (
        .clock        (pixel_clock),
        .reset        (reset),
        .advance_i    (hWrap),
        .count_o      (vCount),
        .sync_o       (vSync),
        .nextActive_o (vNextActive),
        .wrap_o       (vWrap)
    );

    // A horizontal wrap is exactly the step onto pixel 0; a vertical wrap onto (0,0).
    always_comb begin
        blank_d      = !(hNextActive && vNextActive);
        lineStart_d  = hWrap;
        frameStart_d = vWrap;
    end

    // Register the composite signals in step with the axis counters.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            blank_q      <= 1'b1;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            blank_q      <= blank_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign bus.pixel_count = hCount;
    assign bus.line_count  = vCount;
    assign bus.h_synch     = hSync;
    assign bus.v_synch     = vSync;
    assign bus.blank       = blank_q;
    assign bus.line_start  = lineStart_q;
    assign bus.frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three generators (640x480 defaults, default lines with a short
// frame, and a tiny mode with positive syncs) compared each cycle against a raster model.
module tb_vga_timing_gen;

    localparam int N_DEF   = 800 * 525;
    localparam int N_MID   = 800 * 15;
    localparam int N_SMALL = 14 * 7;

    logic clk    = 1'b0;
    logic rstN   = 1'b1;
    logic enable = 1'b0;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(12)) ifDef ();
    vga_timing_gen_if #(.CNT_W(12)) ifMid ();
    vga_timing_gen_if #(.CNT_W(12)) ifSmall ();

    assign ifDef.enable   = enable;
    assign ifMid.enable   = enable;
    assign ifSmall.enable = enable;

    vga_timing_gen dutDef (
        .pixel_clock (clk),
        .reset       (rstN),
        .bus         (ifDef)
    );

    vga_timing_gen #(
        .V_ACTIVE(8), .V_FRONT_PORCH(2), .V_SYNCH(2), .V_BACK_PORCH(3), .H_SYNCH_POL(1'b1)
    ) dutMid (
        .pixel_clock (clk),
        .reset       (rstN),
        .bus         (ifMid)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNCH(2), .H_BACK_PORCH(2),
        .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNCH(1), .V_BACK_PORCH(1),
        .H_SYNCH_POL(1'b1), .V_SYNCH_POL(1'b1)
    ) dutSmall (
        .pixel_clock (clk),
        .reset       (rstN),
        .bus         (ifSmall)
    );

    typedef struct {
        int px;
        int ln;
        bit hs;
        bit vs;
        bit bl;
        bit ls;
        bit fs;
    } exp_t;

    // Raster position k counts enabled steps through the frame; reset sits on the last one.
    int kDef   = N_DEF - 1;
    int kMid   = N_MID - 1;
    int kSmall = N_SMALL - 1;
    bit stepped = 1'b0;
    int edges   = 0;

    int lastFsMid   = 0;
    int lastFsSmall = 0;
    bit seenMid     = 1'b0;
    bit seenSmall   = 1'b0;

    // Reference raster: advance the frame position on each enabled edge.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            kDef    = N_DEF - 1;
            kMid    = N_MID - 1;
            kSmall  = N_SMALL - 1;
            stepped = 1'b0;
        end else begin
            stepped = enable;
            if (enable) begin
                kDef   = (kDef + 1) % N_DEF;
                kMid   = (kMid + 1) % N_MID;
                kSmall = (kSmall + 1) % N_SMALL;
                edges++;
            end
        end
    end

    function automatic exp_t expectAt(input int k, input bit wasStep,
                                      input int ha, input int hf, input int hw, input int hb, input bit hp,
                                      input int va, input int vf, input int vw, input bit vp);
        exp_t e;
        int   ht;
        ht   = ha + hf + hw + hb;
        e.px = k % ht;
        e.ln = k / ht;
        e.hs = (e.px >= ha + hf && e.px < ha + hf + hw) ? hp : !hp;
        e.vs = (e.ln >= va + vf && e.ln < va + vf + vw) ? vp : !vp;
        e.bl = (e.px >= ha) || (e.ln >= va);
        e.ls = wasStep && (e.px == 0);
        e.fs = e.ls && (e.ln == 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkInstance(input string tag, input exp_t e,
                                 input logic [11:0] px, input logic [11:0] ln,
                                 input logic hs, input logic vs, input logic bl,
                                 input logic ls, input logic fs);
        checkOutput({tag, " pixel_count"}, int'(px), e.px);
        checkOutput({tag, " line_count"},  int'(ln), e.ln);
        checkOutput({tag, " h_synch"},     int'(hs), int'(e.hs));
        checkOutput({tag, " v_synch"},     int'(vs), int'(e.vs));
        checkOutput({tag, " blank"},       int'(bl), int'(e.bl));
        checkOutput({tag, " line_start"},  int'(ls), int'(e.ls));
        checkOutput({tag, " frame_start"}, int'(fs), int'(e.fs));
    endtask

    // Whole-output comparison of every instance, plus frame period in enabled edges.
    task automatic compareAll();
        checkInstance("def", expectAt(kDef, stepped, 640, 16, 96, 48, 1'b0, 480, 10, 2, 1'b0),
                      ifDef.pixel_count, ifDef.line_count, ifDef.h_synch, ifDef.v_synch,
                      ifDef.blank, ifDef.line_start, ifDef.frame_start);
        checkInstance("mid", expectAt(kMid, stepped, 640, 16, 96, 48, 1'b1, 8, 2, 2, 1'b0),
                      ifMid.pixel_count, ifMid.line_count, ifMid.h_synch, ifMid.v_synch,
                      ifMid.blank, ifMid.line_start, ifMid.frame_start);
        checkInstance("small", expectAt(kSmall, stepped, 8, 2, 2, 2, 1'b1, 4, 1, 1, 1'b1),
                      ifSmall.pixel_count, ifSmall.line_count, ifSmall.h_synch, ifSmall.v_synch,
                      ifSmall.blank, ifSmall.line_start, ifSmall.frame_start);
        if (!rstN) begin
            seenMid   = 1'b0;
            seenSmall = 1'b0;
        end else begin
            if (ifSmall.frame_start) begin
                if (seenSmall) checkOutput("small frame period", edges - lastFsSmall, 98);
                lastFsSmall = edges;
                seenSmall   = 1'b1;
            end
            if (ifMid.frame_start) begin
                if (seenMid) checkOutput("mid frame period", edges - lastFsMid, 12000);
                lastFsMid = edges;
                seenMid   = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareAll();
    endtask

    task automatic applyStimulus(input bit en, input int cycles);
        enable = en;
        repeat (cycles) tick();
    endtask

    task automatic checkResetLiterals();
        checkOutput("rst def pixel", int'(ifDef.pixel_count), 799);
        checkOutput("rst def line", int'(ifDef.line_count), 524);
        checkOutput("rst def blank", int'(ifDef.blank), 1);
        checkOutput("rst def h_synch", int'(ifDef.h_synch), 1);
        checkOutput("rst def v_synch", int'(ifDef.v_synch), 1);
        checkOutput("rst def line_start", int'(ifDef.line_start), 0);
        checkOutput("rst def frame_start", int'(ifDef.frame_start), 0);
        checkOutput("rst mid line", int'(ifMid.line_count), 14);
        checkOutput("rst mid h_synch", int'(ifMid.h_synch), 0);
        checkOutput("rst small pixel", int'(ifSmall.pixel_count), 13);
        checkOutput("rst small line", int'(ifSmall.line_count), 6);
        checkOutput("rst small h_synch", int'(ifSmall.h_synch), 0);
        checkOutput("rst small v_synch", int'(ifSmall.v_synch), 0);
    endtask

    task automatic checkFirstEdge();
        checkOutput("first def pixel", int'(ifDef.pixel_count), 0);
        checkOutput("first def line", int'(ifDef.line_count), 0);
        checkOutput("first def frame_start", int'(ifDef.frame_start), 1);
        checkOutput("first def line_start", int'(ifDef.line_start), 1);
        checkOutput("first def blank", int'(ifDef.blank), 0);
        checkOutput("first small frame_start", int'(ifSmall.frame_start), 1);
    endtask

    initial begin
        int lowCnt;
        int firstLow;
        int lastLow;
        int blankRise;

        // Power-on reset, outputs checked mid-cycle while reset is held.
        #1 rstN = 1'b0;
        #2 checkResetLiterals();
        applyStimulus(1'b0, 3);

        rstN   = 1'b1;
        enable = 1'b1;
        tick();
        checkFirstEdge();

        // Freeze for five cycles at pixel 100, then resume.
        for (int i = 0; i < 200 && ifDef.pixel_count != 12'd100; i++) tick();
        checkOutput("def reach pixel 100", int'(ifDef.pixel_count), 100);
        enable = 1'b0;
        repeat (5) begin
            tick();
            checkOutput("freeze pixel", int'(ifDef.pixel_count), 100);
            checkOutput("freeze line_start", int'(ifDef.line_start), 0);
        end
        enable = 1'b1;
        tick();
        checkOutput("resume pixel", int'(ifDef.pixel_count), 101);

        // Scan one full default line for sync and blank edges.
        for (int i = 0; i < 900 && ifDef.pixel_count != 12'd0; i++) tick();
        checkOutput("def reach pixel 0", int'(ifDef.pixel_count), 0);
        lowCnt    = 0;
        firstLow  = -1;
        lastLow   = -1;
        blankRise = -1;
        for (int i = 0; i < 800; i++) begin
            if (!ifDef.h_synch) begin
                lowCnt++;
                if (firstLow < 0) firstLow = int'(ifDef.pixel_count);
                lastLow = int'(ifDef.pixel_count);
            end
            if (ifDef.blank && blankRise < 0) blankRise = int'(ifDef.pixel_count);
            tick();
        end
        checkOutput("hsync low cycles", lowCnt, 96);
        checkOutput("hsync first low pixel", firstLow, 656);
        checkOutput("hsync last low pixel", lastLow, 751);
        checkOutput("blank rise pixel", blankRise, 640);
        checkOutput("next line pixel", int'(ifDef.pixel_count), 0);
        checkOutput("blank fall at pixel 0", int'(ifDef.blank), 0);

        // Randomised pixel strobe.
        for (int i = 0; i < 24000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Frame wrap on the short-frame instance.
        enable = 1'b1;
        for (int i = 0; i < 13000 && !(ifMid.pixel_count == 12'd799 && ifMid.line_count == 12'd14); i++) tick();
        checkOutput("mid reach last pixel", int'(ifMid.pixel_count), 799);
        checkOutput("mid reach last line", int'(ifMid.line_count), 14);
        tick();
        checkOutput("mid wrap pixel", int'(ifMid.pixel_count), 0);
        checkOutput("mid wrap line", int'(ifMid.line_count), 0);
        checkOutput("mid wrap frame_start", int'(ifMid.frame_start), 1);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5000 && ifMid.line_count != 12'd5; i++) tick();
        checkOutput("mid reach line 5", int'(ifMid.line_count), 5);
        #2 rstN = 1'b0;
        #1 checkResetLiterals();
        applyStimulus(1'b1, 2);
        rstN   = 1'b1;
        enable = 1'b1;
        tick();
        checkFirstEdge();

        for (int i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16, pixels.
REQ-003 SHALL have parameter H_SYNCH, default 96, pixels.
REQ-004 SHALL have parameter H_BACK_PORCH, default 48, pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT_PORCH, default 10, lines.
REQ-007 SHALL have parameter V_SYNCH, default 2, lines.
REQ-008 SHALL have parameter V_BACK_PORCH, default 33, lines.
REQ-009 SHALL have parameter H_SYNCH_POL, default 0, asserted level of h_synch.
REQ-010 SHALL have parameter V_SYNCH_POL, default 0, asserted level of v_synch.
REQ-011 SHALL have parameter CNT_W, default 12, counter width.
REQ-012 SHALL have port pixel_clock  input  1  single clock, all logic on rising edge.
REQ-013 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-014 SHALL have port enable  input  1  pixel strobe; timing advances only when 1.
REQ-015 SHALL have port h_synch  output  1  horizontal sync, polarity per H_SYNCH_POL.
REQ-016 SHALL have port v_synch  output  1  vertical sync, polarity per V_SYNCH_POL.
REQ-017 SHALL have port blank  output  1  composite blanking, 1 outside the active area.
REQ-018 SHALL have port pixel_count  output  CNT_W  current horizontal position.
REQ-019 SHALL have port line_count  output  CNT_W  current line.
REQ-020 SHALL have port line_start  output  1  one-cycle pulse on the first pixel of each line.
REQ-021 SHALL have port frame_start  output  1  one-cycle pulse on the first pixel of each frame.

Function
REQ-022 SHALL define H_TOTAL = H_ACTIVE+H_FRONT_PORCH+H_SYNCH+H_BACK_PORCH and V_TOTAL likewise.
REQ-023 SHALL increment pixel_count by 1 per enabled edge; at H_TOTAL-1 it SHALL wrap to 0.
REQ-024 SHALL increment line_count only on pixel_count wrap; at V_TOTAL-1 it SHALL wrap to 0 on that same edge.
REQ-025 SHALL register all outputs and keep them aligned: every output in a cycle describes the (pixel_count, line_count) shown in that cycle; no inter-signal skew.
REQ-026 SHALL assert h_synch exactly for pixel_count in [H_ACTIVE+H_FRONT_PORCH, H_ACTIVE+H_FRONT_PORCH+H_SYNCH-1].
REQ-027 SHALL assert v_synch exactly for line_count in [V_ACTIVE+V_FRONT_PORCH, V_ACTIVE+V_FRONT_PORCH+V_SYNCH-1], all pixels of those lines.
REQ-028 SHALL drive blank = 1 when pixel_count >= H_ACTIVE or line_count >= V_ACTIVE, else 0.
REQ-029 SHALL pulse line_start when pixel_count becomes 0, and frame_start when both counts become 0, for one cycle each.
REQ-030 SHALL, while enable = 0, hold counts, syncs and blank, and drive line_start and frame_start to 0.
REQ-031 SHALL fail elaboration if H_TOTAL or V_TOTAL exceeds 2**CNT_W, or any porch or sync width is < 1.

Reset
REQ-032 SHALL, while reset = 0, force pixel_count = H_TOTAL-1, line_count = V_TOTAL-1, blank = 1, h_synch = !H_SYNCH_POL, v_synch = !V_SYNCH_POL, line_start = frame_start = 0, asynchronously.
REQ-033 SHALL make the first enabled edge after reset release show (0,0) with frame_start = line_start = 1.

Structure
REQ-034 SHALL place standard mode constants (640x480@60, 800x600@60) and their totals in shared package vga_timing_pkg.
REQ-035 SHALL implement each axis as one sub-module vga_axis_counter (wrap-counting, sync/active decode), instantiated for horizontal and vertical.

Verification
REQ-036 SHALL check: release reset, enable = 1 -> next cycle pixel_count = 0, line_count = 0, frame_start = 1, line_start = 1, blank = 0.
REQ-037 SHALL check: defaults -> h_synch = 0 for pixel_count 656..751 (96 cycles), 1 elsewhere; v_synch = 0 for lines 490..491 only.
REQ-038 SHALL check: (799,524) -> next (0,0) with frame_start = 1; frame_start period = 420000 enabled cycles.
REQ-039 SHALL check: blank rises at pixel_count 640, falls at 0; line 480 blank for all 800 pixels.
REQ-040 SHALL check: enable = 0 for 5 cycles at pixel_count 100 -> all outputs frozen, pulses 0, resume at 101.
REQ-041 SHALL check: reset = 0 at line 300 -> outputs take REQ-032 values immediately; small mode (H 8/2/2/2, V 4/1/1/1, both polarities 1) -> frame period 98 cycles.
